// File: rtl/layer_scroll_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the play-field scroll sequencer.
// Every layer and the row generator use the same row width.
package layer_scroll_ctrl_pkg;

  localparam int SCROLL_STEPS_DEF = 150;
  localparam int NUM_LAYERS       = 5;
  localparam int LAYER_W          = 7;
  localparam int STEP_W           = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_SCROLL = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  typedef logic [0:LAYER_W-1] row_t;

  // A fully solid row until the generator delivers the first real one.
  localparam row_t ROW_RESET_MAP  = '1;
  localparam row_t ROW_RESET_TYPE = '0;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v,
                                                input logic [STEP_W-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/layer_scroll_ctrl_if.sv
// Signal bundle between the scroll sequencer, game logic, row generator and layers.
// master = the sequencer, slave = everything around it.
interface layer_scroll_ctrl_if;
  import layer_scroll_ctrl_pkg::*;

  logic              module_en;
  logic              scroll_req;
  logic              abort;
  logic              gen_valid;
  row_t              gen_map;
  row_t              gen_type;
  logic              one_ms_tick;
  logic              layer_start;
  logic              layer_load;
  row_t              top_map;
  row_t              top_type;
  logic              gen_req;
  logic              busy;
  logic              scroll_done;
  logic [STEP_W-1:0] step_cnt;

  modport master (
    input  module_en, scroll_req, abort, gen_valid, gen_map, gen_type,
    output one_ms_tick, layer_start, layer_load, top_map, top_type,
           gen_req, busy, scroll_done, step_cnt
  );

  modport slave (
    output module_en, scroll_req, abort, gen_valid, gen_map, gen_type,
    input  one_ms_tick, layer_start, layer_load, top_map, top_type,
           gen_req, busy, scroll_done, step_cnt
  );

endinterface

// File: rtl/layer_scroll_ctrl_tick_gen.sv
// Free-running prescaler producing a registered one-cycle tick every DIV clocks.
// The tick is high in the cycle the count has just wrapped to zero.
module layer_scroll_ctrl_tick_gen #(
  parameter int DIV = 40_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (cnt_reg == LAST);
      if (cnt_reg == LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/layer_scroll_ctrl.sv
// Central scroll sequencer: shared 1 ms tick, start/load strobes to the layer stack,
// scroll step counter and the top-row register refilled from the row generator.
module layer_scroll_ctrl
  import layer_scroll_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 40_000_000,
  parameter int SCROLL_STEPS = SCROLL_STEPS_DEF   // must be 1..256 to fit step_cnt
) (
  input logic                 clk,
  input logic                 rst,
  layer_scroll_ctrl_if.master bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SCROLL_STEPS - 1);

  logic tick;

  layer_scroll_ctrl_tick_gen #(
    .DIV (CLK_HZ / 1000)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic              load_reg, load_next;
  logic              pending_reg, pending_next;
  logic              row_ready_reg, row_ready_next;
  row_t              map_reg, map_next;
  row_t              type_reg, type_next;
  logic              start_pulse, busy_flag, finish_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if ((bus.scroll_req || pending_reg) && bus.module_en && row_ready_reg) begin
          state_next = S_START;
        end
      end
      S_START:  state_next = S_SCROLL;
      // The layers end on the cycle after the terminating tick, so FINISH follows it.
      S_SCROLL: begin
        if (tick && (step_reg == LAST_STEP || load_reg)) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_pulse  = 1'b0;
    busy_flag    = 1'b0;
    finish_pulse = 1'b0;
    case (state_reg)
      S_START: begin
        start_pulse = 1'b1;
        busy_flag   = 1'b1;
      end
      S_SCROLL: busy_flag = 1'b1;
      S_FINISH: begin
        busy_flag    = 1'b1;
        finish_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    step_next      = step_reg;
    load_next      = load_reg;
    pending_next   = pending_reg;
    row_ready_next = row_ready_reg;
    map_next       = map_reg;
    type_next      = type_reg;

    case (state_reg)
      S_START: begin
        step_next = '0;
        load_next = 1'b0;
      end
      S_SCROLL: begin
        if (tick) begin
          step_next = sat_inc(step_reg, LAST_STEP);
        end
        // An abort landing on the final tick just finishes; no load request is raised.
        if (state_next == S_FINISH) begin
          load_next = 1'b0;
        end else if (bus.abort) begin
          load_next = 1'b1;
        end
      end
      default: ;
    endcase

    if (!bus.module_en) begin
      pending_next = 1'b0;
    end else if (state_reg == S_IDLE && state_next == S_START) begin
      pending_next = 1'b0;
    end else if (bus.scroll_req) begin
      pending_next = 1'b1;
    end

    // A row offered alongside gen_req is taken, so the slot never appears empty.
    if (bus.gen_valid && (!row_ready_reg || state_reg == S_FINISH)) begin
      map_next       = bus.gen_map;
      type_next      = bus.gen_type;
      row_ready_next = 1'b1;
    end else if (state_reg == S_FINISH) begin
      row_ready_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg      <= '0;
      load_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      row_ready_reg <= 1'b1;
      map_reg       <= ROW_RESET_MAP;
      type_reg      <= ROW_RESET_TYPE;
    end else begin
      step_reg      <= step_next;
      load_reg      <= load_next;
      pending_reg   <= pending_next;
      row_ready_reg <= row_ready_next;
      map_reg       <= map_next;
      type_reg      <= type_next;
    end
  end

  assign bus.one_ms_tick = tick;
  assign bus.layer_start = start_pulse;
  assign bus.layer_load  = load_reg;
  assign bus.top_map     = map_reg;
  assign bus.top_type    = type_reg;
  assign bus.gen_req     = finish_pulse;
  assign bus.busy        = busy_flag;
  assign bus.scroll_done = finish_pulse;
  assign bus.step_cnt    = step_reg;

endmodule

// File: tb/tb_layer_scroll_ctrl.sv
// Self-checking bench for layer_scroll_ctrl at CLK_HZ=10_000 (10-cycle tick period).
// Completed scrolls are predicted into a queue and checked when scroll_done fires.
module tb_layer_scroll_ctrl;
  import layer_scroll_ctrl_pkg::*;

  localparam int PER   = 10;
  localparam int STEPS = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_scroll_ctrl_if bus_if ();

  layer_scroll_ctrl #(
    .CLK_HZ       (10_000),
    .SCROLL_STEPS (STEPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int         done_cyc;
    logic [7:0] steps;
    row_t       map;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  row_t model_map  = 7'b1111111;
  row_t model_type = 7'b0000000;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic int next_tick(input int c);
    return ((c + PER - 1) / PER) * PER;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  // Scoreboard: every scroll_done pulse is matched against the oldest prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.scroll_done === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: scroll_done at cycle %0d, required no completion", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.done_cyc || bus_if.step_cnt !== e.steps || bus_if.top_map !== e.map ||
              bus_if.gen_req !== 1'b1) begin
            fails++;
            $display("FAIL done_check: cycle=%0d step_cnt=%0d top_map=%b gen_req=%b, required cycle=%0d step_cnt=%0d top_map=%b gen_req=1",
                     cyc, bus_if.step_cnt, bus_if.top_map, bus_if.gen_req, e.done_cyc, e.steps, e.map);
          end else begin
            $display("[TB] scroll done cycle %0d step_cnt %0d top_map %b", cyc, bus_if.step_cnt, bus_if.top_map);
          end
        end
      end
    end
  end

  task automatic offer_row(input row_t m, input row_t t);
    bus_if.gen_valid = 1'b1;
    bus_if.gen_map   = m;
    bus_if.gen_type  = t;
    model_map        = m;
    model_type       = t;
    next_cycle();
    bus_if.gen_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst = 1'b1;
    repeat (3) next_cycle();
    tests++;
    if ({bus_if.one_ms_tick, bus_if.layer_start, bus_if.layer_load, bus_if.gen_req,
         bus_if.busy, bus_if.scroll_done} !== 6'b0 || bus_if.step_cnt !== 8'd0 ||
        bus_if.top_map !== 7'b1111111 || bus_if.top_type !== 7'b0000000) begin
      fails++;
      $display("FAIL reset_values: tick=%b start=%b load=%b gen_req=%b busy=%b done=%b step=%0d map=%b type=%b, required 0s map=1111111 type=0",
               bus_if.one_ms_tick, bus_if.layer_start, bus_if.layer_load, bus_if.gen_req,
               bus_if.busy, bus_if.scroll_done, bus_if.step_cnt, bus_if.top_map, bus_if.top_type);
    end
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      next_cycle();
      exp_tick = (cyc % PER == 0);
      tests++;
      if (bus_if.one_ms_tick !== exp_tick || bus_if.layer_start !== 1'b0 || bus_if.busy !== 1'b0 ||
          bus_if.gen_req !== 1'b0 || bus_if.top_map !== 7'b1111111) begin
        fails++;
        $display("FAIL idle_tick: cycle %0d tick=%b start=%b busy=%b gen_req=%b map=%b, required tick=%b 0 0 0 1111111",
                 cyc, bus_if.one_ms_tick, bus_if.layer_start, bus_if.busy, bus_if.gen_req,
                 bus_if.top_map, exp_tick);
      end
    end
    $display("[TB] reset + 100 idle cycles checked");
  endtask

  task automatic test_full_scroll();
    int   c, t150, extra;
    logic bad;
    c    = cyc;
    t150 = next_tick(c + 2) + (STEPS - 1) * PER;
    bus_if.scroll_req = 1'b1;
    exp_q.push_back('{done_cyc: t150 + 1, steps: 8'(STEPS - 1), map: model_map});
    next_cycle();
    bus_if.scroll_req = 1'b0;
    tests++;
    if (bus_if.layer_start !== 1'b1 || bus_if.busy !== 1'b1) begin
      fails++;
      $display("FAIL full_start: layer_start=%b busy=%b, required 1 1", bus_if.layer_start, bus_if.busy);
    end
    next_cycle();
    tests++;
    if (bus_if.layer_start !== 1'b0 || bus_if.step_cnt !== 8'd0) begin
      fails++;
      $display("FAIL full_start_len: layer_start=%b step_cnt=%0d, required 0 0", bus_if.layer_start, bus_if.step_cnt);
    end
    extra = 0;
    bad   = 1'b0;
    while (cyc < t150) begin
      next_cycle();
      if (bus_if.layer_start === 1'b1) extra++;
      if (bus_if.busy !== 1'b1 || bus_if.scroll_done !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bus_if.step_cnt !== 8'(STEPS - 1) || bus_if.one_ms_tick !== 1'b1 || bad || extra != 0) begin
      fails++;
      $display("FAIL full_last_tick: step_cnt=%0d tick=%b busy_glitch=%b extra_starts=%0d, required 149 1 0 0",
               bus_if.step_cnt, bus_if.one_ms_tick, bad, extra);
    end
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    tests++;
    if (bus_if.layer_load !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.gen_req !== 1'b1) begin
      fails++;
      $display("FAIL full_finish: layer_load=%b busy=%b gen_req=%b, required 0 1 1",
               bus_if.layer_load, bus_if.busy, bus_if.gen_req);
    end
    offer_row(7'b0011001, 7'b1000001);
    tests++;
    if (bus_if.busy !== 1'b0 || bus_if.scroll_done !== 1'b0 || bus_if.top_map !== model_map ||
        bus_if.top_type !== model_type) begin
      fails++;
      $display("FAIL full_after: busy=%b done=%b map=%b type=%b, required 0 0 %b %b",
               bus_if.busy, bus_if.scroll_done, bus_if.top_map, bus_if.top_type, model_map, model_type);
    end
    $display("[TB] full scroll finished, row accepted with gen_req");
  endtask

  task automatic test_abort();
    int   c, t1, a, tn;
    logic bad;
    bus_if.gen_valid = 1'b1;
    bus_if.gen_map   = 7'b1110000;
    bus_if.gen_type  = 7'b0001111;
    next_cycle();
    bus_if.gen_valid = 1'b0;
    next_cycle();
    tests++;
    if (bus_if.top_map !== model_map || bus_if.top_type !== model_type) begin
      fails++;
      $display("FAIL row_ignored: map=%b type=%b, required %b %b", bus_if.top_map, bus_if.top_type, model_map, model_type);
    end
    c  = cyc;
    t1 = next_tick(c + 2);
    a  = t1 + 19 * PER + 5;
    tn = t1 + 20 * PER;
    bus_if.scroll_req = 1'b1;
    exp_q.push_back('{done_cyc: tn + 1, steps: 8'd21, map: model_map});
    next_cycle();
    bus_if.scroll_req = 1'b0;
    run_to(a);
    tests++;
    if (bus_if.step_cnt !== 8'd20 || bus_if.layer_load !== 1'b0) begin
      fails++;
      $display("FAIL abort_pre: step_cnt=%0d layer_load=%b, required 20 0", bus_if.step_cnt, bus_if.layer_load);
    end
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    bad = 1'b0;
    for (int k = a + 1; k <= tn; k++) begin
      if (bus_if.layer_load !== 1'b1 || bus_if.busy !== 1'b1) bad = 1'b1;
      if (k < tn) next_cycle();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_load: layer_load dropped before tick at cycle %0d, required high until then", tn);
    end
    next_cycle();
    tests++;
    if (bus_if.layer_load !== 1'b0 || bus_if.gen_req !== 1'b1) begin
      fails++;
      $display("FAIL abort_finish: layer_load=%b gen_req=%b, required 0 1", bus_if.layer_load, bus_if.gen_req);
    end
    offer_row(7'b1001001, 7'b0110110);
    $display("[TB] aborted scroll checked");
  endtask

  task automatic test_back_to_back();
    int   c, t1, a, tn, done1, starts;
    c     = cyc;
    t1    = next_tick(c + 2);
    a     = t1 + 9 * PER + 5;
    tn    = t1 + 10 * PER;
    done1 = tn + 1;
    bus_if.scroll_req = 1'b1;
    exp_q.push_back('{done_cyc: done1, steps: 8'd11, map: model_map});
    next_cycle();
    bus_if.scroll_req = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      run_to(c + 20 * r);
      bus_if.scroll_req = 1'b1;
      next_cycle();
      bus_if.scroll_req = 1'b0;
    end
    run_to(a);
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    run_to(done1 + 2);
    offer_row(7'b0101010, 7'b0011100);
    tests++;
    if (bus_if.top_map !== 7'b0101010 || bus_if.layer_start !== 1'b0) begin
      fails++;
      $display("FAIL b2b_row: map=%b layer_start=%b, required 0101010 0", bus_if.top_map, bus_if.layer_start);
    end
    next_cycle();
    tests++;
    if (bus_if.layer_start !== 1'b1) begin
      fails++;
      $display("FAIL b2b_start: layer_start=%b at cycle %0d, required 1", bus_if.layer_start, cyc);
    end
    t1 = next_tick(cyc + 1);
    a  = t1 + 4 * PER + 5;
    tn = t1 + 5 * PER;
    exp_q.push_back('{done_cyc: tn + 1, steps: 8'd6, map: model_map});
    run_to(a);
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    run_to(tn + 1);
    offer_row(7'b1010101, 7'b0100010);
    starts = 0;
    repeat (30) begin
      if (bus_if.layer_start === 1'b1) starts++;
      next_cycle();
    end
    tests++;
    if (starts != 0) begin
      fails++;
      $display("FAIL b2b_single: %0d extra scroll starts, required 0", starts);
    end
    $display("[TB] collapsed requests gave one second scroll");
  endtask

  task automatic test_row_wait();
    int   c, t1, a, tn;
    logic bad;
    c  = cyc;
    t1 = next_tick(c + 2);
    a  = t1 + 15;
    tn = t1 + 2 * PER;
    bus_if.scroll_req = 1'b1;
    exp_q.push_back('{done_cyc: tn + 1, steps: 8'd3, map: model_map});
    next_cycle();
    bus_if.scroll_req = 1'b0;
    run_to(a);
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    run_to(tn + 2);
    bus_if.scroll_req = 1'b1;
    next_cycle();
    bus_if.scroll_req = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      if (bus_if.layer_start !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
      next_cycle();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL row_wait_hold: scroll started without a row, required no start");
    end
    offer_row(7'b1100110, 7'b0010100);
    tests++;
    if (bus_if.layer_start !== 1'b0 || bus_if.top_map !== model_map) begin
      fails++;
      $display("FAIL row_wait_accept: layer_start=%b map=%b, required 0 %b", bus_if.layer_start, bus_if.top_map, model_map);
    end
    next_cycle();
    tests++;
    if (bus_if.layer_start !== 1'b1) begin
      fails++;
      $display("FAIL row_wait_start: layer_start=%b at cycle %0d, required 1", bus_if.layer_start, cyc);
    end
    t1 = next_tick(cyc + 1);
    a  = t1 + 5;
    tn = t1 + PER;
    exp_q.push_back('{done_cyc: tn + 1, steps: 8'd2, map: model_map});
    run_to(a);
    bus_if.abort = 1'b1;
    next_cycle();
    bus_if.abort = 1'b0;
    run_to(tn + 1);
    offer_row(7'b0000001, 7'b1000000);
    $display("[TB] pending request waited for row");
  endtask

  task automatic test_disabled();
    logic bad;
    bus_if.module_en  = 1'b0;
    bus_if.scroll_req = 1'b1;
    next_cycle();
    bus_if.scroll_req = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      if (bus_if.layer_start !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
      next_cycle();
    end
    bus_if.module_en = 1'b1;
    repeat (20) begin
      if (bus_if.layer_start !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
      next_cycle();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL disabled_req: scroll started from request while disabled, required none");
    end
    $display("[TB] request ignored while module disabled");
  endtask

  task automatic test_reset_mid();
    int c, t1, done;
    c  = cyc;
    t1 = next_tick(c + 2);
    bus_if.scroll_req = 1'b1;
    next_cycle();
    bus_if.scroll_req = 1'b0;
    run_to(t1 + 74 * PER + 1);
    tests++;
    if (bus_if.step_cnt !== 8'd75 || bus_if.busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_step: step_cnt=%0d busy=%b, required 75 1", bus_if.step_cnt, bus_if.busy);
    end
    rst = 1'b1;
    next_cycle();
    model_map  = 7'b1111111;
    model_type = 7'b0000000;
    tests++;
    if ({bus_if.one_ms_tick, bus_if.layer_start, bus_if.layer_load, bus_if.gen_req,
         bus_if.busy, bus_if.scroll_done} !== 6'b0 || bus_if.step_cnt !== 8'd0 ||
        bus_if.top_map !== model_map || bus_if.top_type !== model_type) begin
      fails++;
      $display("FAIL mid_reset: tick=%b start=%b load=%b gen_req=%b busy=%b done=%b step=%0d map=%b type=%b, required 0s map=1111111 type=0",
               bus_if.one_ms_tick, bus_if.layer_start, bus_if.layer_load, bus_if.gen_req,
               bus_if.busy, bus_if.scroll_done, bus_if.step_cnt, bus_if.top_map, bus_if.top_type);
    end
    rst  = 1'b0;
    c    = cyc;
    done = next_tick(c + 2) + (STEPS - 1) * PER + 1;
    bus_if.scroll_req = 1'b1;
    exp_q.push_back('{done_cyc: done, steps: 8'(STEPS - 1), map: model_map});
    next_cycle();
    bus_if.scroll_req = 1'b0;
    tests++;
    if (bus_if.layer_start !== 1'b1) begin
      fails++;
      $display("FAIL mid_restart: layer_start=%b, required 1", bus_if.layer_start);
    end
    run_to(done + 1);
    tests++;
    if (bus_if.busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_full_end: busy=%b, required 0", bus_if.busy);
    end
    $display("[TB] reset mid-scroll then full scroll");
  endtask

  initial begin
    bus_if.module_en  = 1'b1;
    bus_if.scroll_req = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.gen_valid  = 1'b0;
    bus_if.gen_map    = 7'b0000000;
    bus_if.gen_type   = 7'b0000000;

    test_reset();
    test_full_scroll();
    test_abort();
    test_back_to_back();
    test_row_wait();
    test_disabled();
    test_reset_mid();

    repeat (3) next_cycle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d predicted completions never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_scroll_ctrl.md
Name: layer_scroll_ctrl

Overview:
- Central sequencer for the five shift_layer instances of the play-field.
- Generates the shared 1 ms tick and the start/load strobes.
- Counts the scroll in lock-step with the layers, and owns the top-row map/type register fed into layer 0.
- Requests a fresh random row from the row generator after every completed scroll; sits between game logic (scroll requests) and the layer stack.

Parameters:
- CLK_HZ, 40_000_000, pixel clock frequency; the tick period is CLK_HZ/1000 cycles.
- SCROLL_STEPS, 150, number of 1 ms ticks (pixels) in one full layer scroll; matches the layer height.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- module_en  in  1  game running; scroll requests are ignored when low
- scroll_req  in  1  one-cycle request: the player reached the upper layer
- abort  in  1  one-cycle request to terminate a scroll early (game over)
- gen_valid  in  1  row generator has a new row on gen_map/gen_type
- gen_map  in  7  [0:6] new layer map
- gen_type  in  7  [0:6] new block types
- one_ms_tick  out  1  one-cycle pulse every CLK_HZ/1000 clocks, to all layers
- layer_start  out  1  one-cycle start strobe to all layers
- layer_load  out  1  early-end request to all layers, held until the next tick
- top_map  out  7  [0:6] map driven into layer 0 layer_map_in
- top_type  out  7  [0:6] type driven into layer 0 block_type_in
- gen_req  out  1  one-cycle pulse requesting the next random row
- busy  out  1  high from the layer_start cycle through FINISH
- scroll_done  out  1  one-cycle pulse when a scroll completes (full or aborted)
- step_cnt  out  8  ticks elapsed in the current scroll

Behaviour:
- Reset values: every output 0, except top_map = 7'b1111111 and top_type = 0. Internal state on reset: prescaler 0, state IDLE, pending 0, row_ready 1.
- Tick prescaler is free-running, 0..CLK_HZ/1000-1. one_ms_tick is high in the cycle the count wraps to 0. The prescaler is never reset by scrolling.
- pending flag:
  - Set by scroll_req when module_en=1 and the state is not IDLE.
  - A scroll_req in IDLE is consumed directly.
  - Multiple requests while busy collapse into one pending request.
  - Cleared when a scroll starts and when module_en=0.
- State IDLE:
  - Leave when (scroll_req | pending) & module_en & row_ready, going to START.
  - If row_ready=0, the request is held in pending.
- State START (1 cycle):
  - layer_start=1, step_cnt<=0, busy=1, then go to SCROLL.
- State SCROLL:
  - On each tick, step_cnt+1.
  - On the tick where step_cnt==SCROLL_STEPS-1, go to FINISH.
  - If abort is seen, layer_load<=1 and stays high until the next tick. On that tick layer_load<=0 and the state goes to FINISH.
  - abort and the final tick in the same cycle: go to FINISH; layer_load is not asserted.
- Timing alignment: FINISH must coincide with the layers' S_END cycle, i.e. the cycle after the terminating tick.
- State FINISH (1 cycle):
  - scroll_done=1, gen_req=1, row_ready<=0, busy stays 1, then go to IDLE.
- Row handshake:
  - gen_valid while row_ready=0: top_map<=gen_map, top_type<=gen_type, row_ready<=1.
  - gen_valid while row_ready=1 is ignored.
  - gen_valid in the same cycle as gen_req is accepted.
- top_map/top_type are stable throughout a scroll. They change only in IDLE or FINISH+n, never between START and FINISH.
- module_en falling mid-scroll: the current scroll completes normally; no new scroll starts.
- Reset mid-scroll returns to IDLE immediately. Layers share rst and reset in the same cycle.
- step_cnt saturates at SCROLL_STEPS-1. Its width is fixed at 8 bits, so SCROLL_STEPS must be at most 256.

Decomposition:
- Shared package (macros.vh): SCROLL_STEPS default, layer count (5), layer width (7), and state encodings S_IDLE/S_START/S_SCROLL/S_FINISH.
- One natural sub-module: tick_gen (parameter DIV = CLK_HZ/1000; ports clk, rst, tick), reusable for the other timed game blocks.

Test Plan (CLK_HZ=10_000, so the tick period is 10 clk; SCROLL_STEPS=150):
- Reset then idle 100 cycles -> one_ms_tick pulses at cycles 10, 20, …; all strobes 0; top_map=1111111.
- scroll_req in IDLE, module_en=1 -> layer_start for exactly 1 cycle; FINISH 1 cycle after the 150th tick with step_cnt=149; scroll_done and gen_req pulse together once; busy drops after FINISH.
- abort on the 20th tick window of a scroll -> layer_load high until the next tick, then FINISH; step_cnt≈20–21; scroll_done pulses once.
- Three scroll_req during a scroll, gen_valid with gen_map=0101010 2 cycles after gen_req -> exactly one second scroll starts; top_map=0101010 from before the second layer_start.
- gen_valid withheld after FINISH, then scroll_req -> no layer_start until gen_valid arrives; scroll starts in the cycle after gen_valid is accepted.
- rst asserted at step 75 -> next cycle all outputs at reset values; a later scroll_req runs a full 150-tick scroll.
